// File: rtl/sp_ram_ctrl_if.sv
// Requester-side bus of sp_ram_ctrl: packed per-requester request slices plus
// one-hot grant/response and a shared registered read-data return.
interface sp_ram_ctrl_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr;
  logic [NUM_REQ-1:0]              we;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] be;
  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              rvalid;
  logic [DATA_WIDTH-1:0]           rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sp_ram_ctrl.sv
// Round-robin controller sharing one single-port RAM between NUM_REQ requesters,
// with an optional zero-fill sequence after reset before the first grant.
module sp_ram_ctrl #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTES  = 256,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  sp_ram_ctrl_if.slave            bus_if,
  output logic                    init_done_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned Blocks  = NUM_BYTES / BeWidth;
  localparam int unsigned OffW    = $clog2(BeWidth);
  localparam int unsigned CntW    = (Blocks > 1) ? $clog2(Blocks) : 1;
  localparam int unsigned PtrW    = $clog2(NUM_REQ);

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  logic                  state_q, state_d;
  logic [CntW-1:0]       init_cnt_q, init_cnt_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  init_done_q, init_done_d;

  logic                  win_valid;
  logic [PtrW-1:0]       win_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [BeWidth-1:0]    sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  ram_en, ram_we;

  // Round-robin search starting at rr_ptr_q, then mux the winner's payload.
  always_comb begin
    int unsigned     cand;
    logic [PtrW-1:0] cand_idx;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = PtrW'(cand);
      if (!win_valid && bus_if.req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end

    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    gnt       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PtrW'(k)) begin
        sel_addr  = bus_if.addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = bus_if.we[k];
        sel_be    = bus_if.be[k*BeWidth +: BeWidth];
        sel_wdata = bus_if.wdata[k*DATA_WIDTH +: DATA_WIDTH];
        gnt[k]    = rst_ni && (state_q == StRun) && win_valid;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr_o  = sel_addr;
    ram_be_o    = sel_be;
    ram_wdata_o = sel_wdata;

    if (state_q == StInit) begin
      ram_en      = 1'b1;
      ram_we      = 1'b1;
      ram_addr_o  = ADDR_WIDTH'(init_cnt_q) << OffW;
      ram_be_o    = '1;
      ram_wdata_o = '0;
      init_cnt_d  = init_cnt_q + 1'b1;
      if (init_cnt_q == CntW'(Blocks - 1)) begin
        state_d = StRun;
      end
    end else if (win_valid) begin
      ram_en   = 1'b1;
      ram_we   = sel_we;
      rvalid_d = gnt;
      rdata_d  = sel_we ? '0 : ram_rdata_i;
      rr_ptr_d = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    init_done_d = (state_d == StRun);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= INIT_ZERO ? StInit : StRun;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  // RAM strobes and grants are forced low for the whole reset cycle.
  assign ram_en_o      = rst_ni & ram_en;
  assign ram_we_o      = rst_ni & ram_we;
  assign bus_if.gnt    = gnt;
  assign bus_if.rvalid = rvalid_q;
  assign bus_if.rdata  = rdata_q;
  assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: behavioural RAM, cycle monitor with a reference memory
// and round-robin model feeding a response scoreboard, plus directed scenarios.
module tb_sp_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        ram_en;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sp_ram_ctrl_if #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_if ();

  sp_ram_ctrl #(
    .NUM_REQ   (2),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_BYTES (256),
    .INIT_ZERO (1'b1)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus_if     (bus_if),
    .init_done_o(init_done),
    .ram_en_o   (ram_en),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_be_o   (ram_be),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM seeded with non-zero junk so a missing fill shows up.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] ref_mem [64];
  int          m_init_left;
  int          m_rr;
  logic [31:0] m_last;

  // Monitor: scores responses, then predicts this cycle's grant and RAM access.
  initial begin
    rsp_t r;
    int   k;
    int   idx;
    m_init_left = 64;
    m_rr        = 0;
    m_last      = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check("rvalid", 64'(bus_if.rvalid), 64'(r.v));
        check("rdata", 64'(bus_if.rdata), 64'(r.d));
        m_last = r.d;
      end else begin
        check("rvalid_idle", 64'(bus_if.rvalid), 64'(0));
        check("rdata_hold", 64'(bus_if.rdata), 64'(m_last));
      end

      if (!rst_n) begin
        check("rst_gnt", 64'(bus_if.gnt), 64'(0));
        check("rst_ram_en", 64'(ram_en), 64'(0));
        check("rst_ram_we", 64'(ram_we), 64'(0));
        m_init_left = 64;
        m_rr        = 0;
        m_last      = '0;
        sb.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      end else if (m_init_left > 0) begin
        check("init_gnt", 64'(bus_if.gnt), 64'(0));
        check("init_done_low", 64'(init_done), 64'(0));
        check("init_wr", 64'({ram_en, ram_we, ram_be}), 64'(6'b11_1111));
        check("init_addr", 64'(ram_addr), 64'((64 - m_init_left) * 4));
        check("init_wdata", 64'(ram_wdata), 64'(0));
        m_init_left--;
      end else begin
        check("init_done_high", 64'(init_done), 64'(1));
        k = -1;
        for (int i = 0; i < 2; i++) begin
          if (k < 0 && bus_if.req[(m_rr + i) % 2]) k = (m_rr + i) % 2;
        end
        if (k < 0) begin
          check("gnt_none", 64'(bus_if.gnt), 64'(0));
          check("ram_en_idle", 64'(ram_en), 64'(0));
        end else begin
          check("gnt", 64'(bus_if.gnt), 64'(2'b01 << k));
          check("ram_en", 64'(ram_en), 64'(1));
          check("ram_addr", 64'(ram_addr), 64'(bus_if.addr[k*8 +: 8]));
          check("ram_we", 64'(ram_we), 64'(bus_if.we[k]));
          idx  = int'(bus_if.addr[k*8+2 +: 6]);
          r.v  = 2'b01 << k;
          r.d  = bus_if.we[k] ? 32'h0 : ref_mem[idx];
          sb.push_back(r);
          if (bus_if.we[k]) begin
            for (int b = 0; b < 4; b++) begin
              if (bus_if.be[k*4 + b]) ref_mem[idx][8*b +: 8] = bus_if.wdata[k*32 + 8*b +: 8];
            end
          end
          m_rr = (k + 1) % 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic r, input logic w, input logic [7:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    bus_if.req[k]          = r;
    bus_if.we[k]           = w;
    bus_if.addr[k*8 +: 8]  = a;
    bus_if.be[k*4 +: 4]    = b;
    bus_if.wdata[k*32 +: 32] = d;
  endtask

  // Counts grant-free cycles with requests held; bounded so a stuck fill cannot hang.
  task automatic wait_init(output int n);
    n = 0;
    #1;
    while (bus_if.gnt == 2'b00 && n < 200) begin
      n++;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  g;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h00, 4'hf, 32'h0);
    set_req(1, 1'b1, 1'b0, 8'h04, 4'hf, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill with both requests held, then first grant to requester 0.
    wait_init(n);
    check("init_len", 64'(n), 64'(64));
    check("first_gnt", 64'(bus_if.gnt), 64'(2'b01));
    check("init_done_rise", 64'(init_done), 64'(1));

    // Alternation with both requesting.
    for (int i = 0; i < 6; i++) begin
      check("alt_gnt", 64'(bus_if.gnt), 64'((i % 2) ? 2'b10 : 2'b01));
      tick();
      #1;
    end

    // Requester 1 reads a zero-filled word.
    set_req(0, 1'b0, 1'b0, 8'h00, 4'hf, 32'h0);
    set_req(1, 1'b1, 1'b0, 8'h40, 4'hf, 32'h0);
    #1 check("rd40_gnt", 64'(bus_if.gnt), 64'(2'b10));
    tick();
    set_req(1, 1'b0, 1'b0, 8'h40, 4'hf, 32'h0);
    check("rd40_rvalid", 64'(bus_if.rvalid), 64'(2'b10));
    check("rd40_rdata", 64'(bus_if.rdata), 64'(32'h0));

    // Partial write then back-to-back read of the same word.
    set_req(0, 1'b1, 1'b1, 8'h10, 4'b0101, 32'hDEADBEEF);
    tick();
    set_req(0, 1'b1, 1'b0, 8'h10, 4'hf, 32'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 8'h10, 4'hf, 32'h0);
    check("rmw_rdata", 64'(bus_if.rdata), 64'(32'h00AD00EF));

    // Only requester 1, then both: pointer returns to requester 0.
    set_req(1, 1'b1, 1'b0, 8'h44, 4'hf, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 check("solo1_gnt", 64'(bus_if.gnt), 64'(2'b10));
      tick();
    end
    set_req(0, 1'b1, 1'b0, 8'h08, 4'hf, 32'h0);
    #1 check("rr_back0", 64'(bus_if.gnt), 64'(2'b01));
    tick();

    // Reset in RUN then again at fill cycle 30.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("refill_done_low", 64'(init_done), 64'(0));
    wait_init(n);
    check("refill_len", 64'(n), 64'(64));

    // Read in flight, then reset: response must be cleared after the reset edge.
    tick();
    set_req(1, 1'b0, 1'b0, 8'h00, 4'hf, 32'h0);
    set_req(0, 1'b1, 1'b0, 8'h10, 4'hf, 32'h0);
    #1 check("flight_gnt", 64'(bus_if.gnt), 64'(2'b01));
    tick();
    set_req(0, 1'b0, 1'b0, 8'h10, 4'hf, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("flight_dropped", 64'(bus_if.rvalid), 64'(0));
    set_req(0, 1'b1, 1'b0, 8'h00, 4'hf, 32'h0);
    set_req(1, 1'b1, 1'b0, 8'h04, 4'hf, 32'h0);
    wait_init(n);
    check("fill3_len", 64'(n), 64'(64));

    // Random traffic; payload only changes once granted or idle.
    for (int c = 0; c < 80; c++) begin
      #1 g = bus_if.gnt;
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!bus_if.req[k] || g[k]) begin
          set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 4'($urandom), $urandom);
        end
      end
    end

    set_req(0, 1'b0, 1'b0, 8'h00, 4'hf, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 4'hf, 32'h0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
